mem_req_arbiter: RTL

Shares the single memory port between the instruction-fetch requester (IF) and the data requester (MEM stage) of the pipelined RISC-V core. One transaction is in flight at a time. Data requests win by default, because the older in-pipeline instruction must complete first. A starvation limiter guarantees fetch progress. Read responses are routed back to the owning requester through the same valid/ready handshake the stages already use.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_req_arbiter_if.sv | 57 +++++
 rtl/mem_arb_starve_cnt.sv | 46 ++++
 rtl/mem_req_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the memory request arbiter.
// The FSM and owner enums are imported by both the top and its counter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 4;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  // Legal starvation limits fit the 4-bit counter and must allow at least one data grant.
  function automatic logic starve_lim_legal(input int lim);
    return (lim >= 1) && (lim <= 15);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundles the IF requester, MEM requester and memory port of the arbiter.
// slave is the arbiter's view; master is the view of the stages and the memory.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Instruction-fetch requester
  logic              inst_req_valid;
  logic              inst_req_ready;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_rdata_valid;
  logic              inst_rdata_ready;

  // Data (MEM stage) requester
  logic              data_req_valid;
  logic              data_req_ready;
  logic [ADDR_W-1:0] data_addr;
  logic              data_wen;
  logic [DATA_W-1:0] data_wdata;
  logic [STRB_W-1:0] data_wstrb;
  logic [DATA_W-1:0] data_rdata;
  logic              data_rdata_valid;
  logic              data_rdata_ready;

  // Shared memory port
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;
  logic              mem_rdata_ready;

  modport slave (
    input  inst_req_valid, inst_addr, inst_rdata_ready,
    input  data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_rdata_ready,
    input  mem_req_ready, mem_rdata, mem_rdata_valid,
    output inst_req_ready, inst_rdata, inst_rdata_valid,
    output data_req_ready, data_rdata, data_rdata_valid,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rdata_ready
  );

  modport master (
    output inst_req_valid, inst_addr, inst_rdata_ready,
    output data_req_valid, data_addr, data_wen, data_wdata, data_wstrb, data_rdata_ready,
    output mem_req_ready, mem_rdata, mem_rdata_valid,
    input  inst_req_ready, inst_rdata, inst_rdata_valid,
    input  data_req_ready, data_rdata, data_rdata_valid,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_rdata_ready
  );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive data grants taken while a fetch is waiting; once the
// count reaches STARVE_LIM, force_inst hands the next grant to fetch.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic inst_grant,
  input  logic inst_waiting,
  output logic force_inst
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(STARVE_LIM);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: hold value assigned first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (inst_grant) begin
      cnt_d = '0;
    end else if (data_grant) begin
      if (!inst_waiting) begin
        cnt_d = '0;
      end else if (cnt_q != LIM) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_inst = (cnt_q == LIM);

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, one
// transaction at a time, with data priority and a fetch starvation limiter.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wen_q,   wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic in_idle;
  logic in_addr;
  logic in_resp;
  logic force_inst;
  logic grant_inst;
  logic grant_data;
  logic owner_rdy;
  logic mem_req_hs;
  logic mem_rsp_hs;
  logic resp_inst;
  logic resp_data;

  // Every output is qualified by a state decode that is forced low while rst is high.
  assign in_idle = !rst && (state_q == IDLE);
  assign in_addr = !rst && (state_q == ADDR);
  assign in_resp = !rst && (state_q == RESP);

  // Data wins unless fetch has been passed over STARVE_LIM times in a row.
  assign grant_inst = in_idle && bus.inst_req_valid && (!bus.data_req_valid || force_inst);
  assign grant_data = in_idle && bus.data_req_valid && !grant_inst;

  assign owner_rdy  = (owner_q == DATA) ? bus.data_rdata_ready : bus.inst_rdata_ready;
  assign mem_req_hs = in_addr && bus.mem_req_ready;
  assign mem_rsp_hs = in_resp && bus.mem_rdata_valid && owner_rdy;
  assign resp_inst  = in_resp && (owner_q == INST);
  assign resp_data  = in_resp && (owner_q == DATA);

  mem_arb_starve_cnt #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starve_cnt (
    .clk         (clk),
    .rst         (rst),
    .data_grant  (grant_data),
    .inst_grant  (grant_inst),
    .inst_waiting(bus.inst_req_valid),
    .force_inst  (force_inst)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          owner_d = DATA;
          addr_d  = bus.data_addr;
          wen_d   = bus.data_wen;
          wdata_d = bus.data_wdata;
          wstrb_d = bus.data_wstrb;
          state_d = ADDR;
        end else if (grant_inst) begin
          // Fetches are always reads with no byte lanes enabled.
          owner_d = INST;
          addr_d  = bus.inst_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mem_req_hs) begin
          state_d = wen_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (mem_rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= INST;
      // NOTE: the latched request fields are plain flops, so clearing them in reset is cheap and keeps outputs deterministic.
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign bus.inst_req_ready = grant_inst;
  assign bus.data_req_ready = grant_data;

  assign bus.mem_req_valid  = in_addr;
  assign bus.mem_addr       = in_addr ? addr_q  : '0;
  assign bus.mem_wen        = in_addr && wen_q;
  assign bus.mem_wdata      = in_addr ? wdata_q : '0;
  assign bus.mem_wstrb      = in_addr ? wstrb_q : '0;

  // Response path is a zero-latency pass-through steered by the owner.
  assign bus.mem_rdata_ready  = in_resp && owner_rdy;
  assign bus.inst_rdata_valid = resp_inst && bus.mem_rdata_valid;
  assign bus.data_rdata_valid = resp_data && bus.mem_rdata_valid;
  assign bus.inst_rdata       = resp_inst ? bus.mem_rdata : '0;
  assign bus.data_rdata       = resp_data ? bus.mem_rdata : '0;

endmodule
